// File: rtl/lcd_pkg.sv
// Shared types and panel table constants for LCD panel identification.
// Pure declarations: no latency, no flow control.
package lcd_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    DECODE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic [1:0]  clk_sel;
  } panel_cfg_t;

  localparam panel_cfg_t FALLBACK_CFG = '{id: ID_4342, h_disp: 11'd480, v_disp: 11'd272, clk_sel: 2'd0};

endpackage

// File: rtl/lcd_id_decode.sv
// Maps the 3 debounced ID straps to a panel configuration; combinational, zero latency.
// No flow control: unknown straps or a forced error select the fallback and raise err.
module lcd_id_decode
  import lcd_pkg::*;
(
  input  logic [2:0]  raw,
  input  logic        force_err,
  output panel_cfg_t  cfg,
  output logic        err
);

  always_comb begin
    cfg = FALLBACK_CFG;
    err = 1'b0;
    if (force_err) begin
      err = 1'b1;
    end else begin
      case (raw)
        3'b000:  cfg = '{id: ID_4342, h_disp: 11'd480,  v_disp: 11'd272, clk_sel: 2'd0};
        3'b001:  cfg = '{id: ID_7084, h_disp: 11'd800,  v_disp: 11'd480, clk_sel: 2'd1};
        3'b010:  cfg = '{id: ID_7016, h_disp: 11'd1024, v_disp: 11'd600, clk_sel: 2'd2};
        3'b100:  cfg = '{id: ID_4384, h_disp: 11'd800,  v_disp: 11'd480, clk_sel: 2'd1};
        3'b101:  cfg = '{id: ID_1018, h_disp: 11'd1280, v_disp: 11'd800, clk_sel: 2'd3};
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lcd_id_ctrl.sv
// Power-up LCD panel ID sequencer: release bus, settle, debounce straps, decode, return bus.
// id_valid rises SETTLE_CYC+STABLE_CNT+1 cycles after reset release with clean straps; no backpressure.
module lcd_id_ctrl
  import lcd_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int STABLE_CNT = 8,
  parameter int MAX_GLITCH = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lcd_rgb,
  input  logic        rescan,
  output logic        lcd_rgb_oe,
  output logic        id_valid,
  output logic        id_err,
  output logic [15:0] id_lcd,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [1:0]  clk_sel
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int STB_W = $clog2(STABLE_CNT + 1);
  localparam int GL_W  = $clog2(MAX_GLITCH + 1);

  logic [2:0]  sync_meta_q, raw;
  state_e      state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [GL_W-1:0]  glitch_q, glitch_d;
  logic [2:0]  cand_q, cand_d;
  logic        force_err_q, force_err_d;
  logic        oe_q, oe_d;
  logic        id_valid_q, id_valid_d;
  logic        id_err_q, id_err_d;
  panel_cfg_t  cfg_q, cfg_d;
  panel_cfg_t  dec_cfg;
  logic        dec_err;

  // Straps are asynchronous to clk: two-stage synchronizer, packed as {B7, G7, R7}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      raw         <= '0;
    end else begin
      sync_meta_q <= {lcd_rgb[4], lcd_rgb[10], lcd_rgb[15]};
      raw         <= sync_meta_q;
    end
  end

  // cand_q equals the last accepted sample whenever the stable run completes.
  lcd_id_decode u_decode (
    .raw       (cand_q),
    .force_err (force_err_q),
    .cfg       (dec_cfg),
    .err       (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    stable_d    = stable_q;
    glitch_d    = glitch_q;
    cand_d      = cand_q;
    force_err_d = force_err_q;
    oe_d        = oe_q;
    id_valid_d  = id_valid_q;
    id_err_d    = id_err_q;
    cfg_d       = cfg_q;
    case (state_q)
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d  = SAMPLE;
          settle_d = '0;
          stable_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (stable_q == '0) begin
          cand_d   = raw;
          stable_d = STB_W'(1);
        end else if (raw == cand_q) begin
          stable_d = stable_q + 1'b1;
          if (stable_q == STB_W'(STABLE_CNT - 1)) state_d = DECODE;
        end else begin
          cand_d   = raw;
          stable_d = STB_W'(1);
          glitch_d = glitch_q + 1'b1;
          if (glitch_q == GL_W'(MAX_GLITCH - 1)) begin
            state_d     = DECODE;
            force_err_d = 1'b1;
          end
        end
      end
      DECODE: begin
        cfg_d      = dec_cfg;
        id_err_d   = dec_err;
        id_valid_d = 1'b1;
        oe_d       = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        // Geometry stays as-is so the driver keeps a sane config until the next decode.
        if (rescan) begin
          state_d     = SETTLE;
          id_valid_d  = 1'b0;
          oe_d        = 1'b0;
          id_err_d    = 1'b0;
          settle_d    = '0;
          stable_d    = '0;
          glitch_d    = '0;
          force_err_d = 1'b0;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SETTLE;
      settle_q    <= '0;
      stable_q    <= '0;
      glitch_q    <= '0;
      cand_q      <= '0;
      force_err_q <= 1'b0;
      oe_q        <= 1'b0;
      id_valid_q  <= 1'b0;
      id_err_q    <= 1'b0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      stable_q    <= stable_d;
      glitch_q    <= glitch_d;
      cand_q      <= cand_d;
      force_err_q <= force_err_d;
      oe_q        <= oe_d;
      id_valid_q  <= id_valid_d;
      id_err_q    <= id_err_d;
      cfg_q       <= cfg_d;
    end
  end

  assign lcd_rgb_oe = oe_q;
  assign id_valid   = id_valid_q;
  assign id_err     = id_err_q;
  assign id_lcd     = cfg_q.id;
  assign h_disp     = cfg_q.h_disp;
  assign v_disp     = cfg_q.v_disp;
  assign clk_sel    = cfg_q.clk_sel;

endmodule

// File: tb/tb_lcd_id_ctrl.sv
// Directed bench for lcd_id_ctrl: stimulus pushes expected panel configs, a monitor
// pops and compares on every id_valid rising edge.
module tb_lcd_id_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lcd_rgb;
  logic        rescan;
  logic        lcd_rgb_oe, id_valid, id_err;
  logic [15:0] id_lcd;
  logic [10:0] h_disp, v_disp;
  logic [1:0]  clk_sel;

  typedef struct {
    logic        err;
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  cs;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_v = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lcd_id_ctrl #(.SETTLE_CYC(16), .STABLE_CNT(4), .MAX_GLITCH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_rgb    (lcd_rgb),
    .rescan     (rescan),
    .lcd_rgb_oe (lcd_rgb_oe),
    .id_valid   (id_valid),
    .id_err     (id_err),
    .id_lcd     (id_lcd),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .clk_sel    (clk_sel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Straps {B7,G7,R7} on pins 4/10/15; the other pins carry junk that must be ignored.
  function automatic logic [15:0] pins(input logic [2:0] r);
    logic [15:0] v;
    v = 16'h2B29;
    v[15] = r[0];
    v[10] = r[1];
    v[4]  = r[2];
    return v;
  endfunction

  function automatic exp_t mk(input logic e, input logic [15:0] id, input int h, input int v,
                              input int cs);
    exp_t x;
    x.err = e; x.id = id; x.h = 11'(h); x.v = 11'(v); x.cs = 2'(cs);
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n && id_valid && !prev_v) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got id %h with no expected entry", id_lcd);
      end else begin
        cur = sb.pop_front();
        chk("id_lcd",  32'(id_lcd),  32'(cur.id));
        chk("h_disp",  32'(h_disp),  32'(cur.h));
        chk("v_disp",  32'(v_disp),  32'(cur.v));
        chk("clk_sel", 32'(clk_sel), 32'(cur.cs));
        chk("id_err",  32'(id_err),  32'(cur.err));
      end
    end
    prev_v = id_valid;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"},    32'(lcd_rgb_oe), 32'd0);
    chk({tag, "_valid"}, 32'(id_valid),   32'd0);
    chk({tag, "_err"},   32'(id_err),     32'd0);
    chk({tag, "_id"},    32'(id_lcd),     32'd0);
    chk({tag, "_h"},     32'(h_disp),     32'd0);
    chk({tag, "_v"},     32'(v_disp),     32'd0);
    chk({tag, "_cs"},    32'(clk_sel),    32'd0);
  endtask

  // Called just after reset release; counts edges and checks the exact rise at edge 21.
  task automatic latency_check(input int rescan_at);
    int early = 0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k < 21 && (lcd_rgb_oe || id_valid)) early++;
      rescan = (k == rescan_at);
    end
    rescan = 1'b0;
    chk("oe_low_before_21", 32'(early), 32'd0);
    chk("valid_at_21", 32'(id_valid), 32'd1);
    chk("oe_at_21", 32'(lcd_rgb_oe), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !id_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("valid_timeout", 32'(id_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_rescan(input logic [2:0] r, input logic [15:0] old_id, input int old_h);
    @(posedge clk); #1;
    lcd_rgb = pins(r);
    rescan = 1'b1;
    @(posedge clk); #1;
    rescan = 1'b0;
    chk("rescan_valid", 32'(id_valid), 32'd0);
    chk("rescan_oe", 32'(lcd_rgb_oe), 32'd0);
    chk("rescan_err", 32'(id_err), 32'd0);
    chk("rescan_id_held", 32'(id_lcd), 32'(old_id));
    chk("rescan_h_held", 32'(h_disp), 32'(old_h));
  endtask

  initial begin
    rst_n = 1'b0;
    rescan = 1'b0;
    lcd_rgb = pins(3'b001);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");

    // Clean 001 from reset.
    @(negedge clk) rst_n = 1'b1;
    sb.push_back(mk(1'b0, 16'h7084, 800, 480, 1));
    latency_check(0);

    // 101 with a single-sample glitch to 100 inside the stable run.
    do_rescan(3'b101, 16'h7084, 800);
    sb.push_back(mk(1'b0, 16'h1018, 1280, 800, 3));
    repeat (17) @(posedge clk);
    #1 lcd_rgb = pins(3'b100);
    @(posedge clk);
    #1 lcd_rgb = pins(3'b101);
    wait_valid(60);

    // Straps toggling 000/010 every cycle: glitch limit forces fallback.
    do_rescan(3'b000, 16'h1018, 1280);
    sb.push_back(mk(1'b1, 16'h4342, 480, 272, 0));
    for (int i = 0; i < 80 && !id_valid; i++) begin
      @(posedge clk); #1;
      lcd_rgb = pins((i % 2 == 0) ? 3'b010 : 3'b000);
    end
    wait_valid(1);

    // Unknown strap code 111.
    do_rescan(3'b111, 16'h4342, 480);
    sb.push_back(mk(1'b1, 16'h4342, 480, 272, 0));
    wait_valid(60);

    // 010, then rescan to 100: old config held until the new decode.
    do_rescan(3'b010, 16'h4342, 480);
    sb.push_back(mk(1'b0, 16'h7016, 1024, 600, 2));
    wait_valid(60);
    do_rescan(3'b100, 16'h7016, 1024);
    sb.push_back(mk(1'b0, 16'h4384, 800, 480, 1));
    wait_valid(60);

    // Reset during SAMPLE, then full sequence again with an ignored rescan in SETTLE.
    do_rescan(3'b001, 16'h4384, 800);
    repeat (18) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sb.push_back(mk(1'b0, 16'h7084, 800, 480, 1));
    latency_check(5);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
